// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the MW-stage LSU state encoding.
// Contents: opcode/funct3 localparams for loads and stores, lsu_state_e.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
// Ports: funct3/off select size and lane; rs2 -> wmask/wdata (store lanes),
//        rdata -> ldata (extracted and sign/zero-extended load value).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store: replicate the source across lanes so the mask alone picks the lane.
  always_comb begin
    wmask = 4'b1111;
    wdata = rs2;
    case (funct3[1:0])
      2'b00: begin
        wmask = 4'b0001 << off;
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << off;
        wdata = {2{rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: halfwords are aligned, so only off[1] selects the half.
  always_comb begin
    rbyte = rdata[{off, 3'b000} +: 8];
    rhalf = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ldata = {{24{rbyte[7]}}, rbyte};
      F3_H:    ldata = {{16{rhalf[15]}}, rhalf};
      F3_BU:   ldata = {24'd0, rbyte};
      F3_HU:   ldata = {16'd0, rhalf};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mw.sv
// MW-stage load/store unit: one req/ack bus transaction per aligned access,
// load formatting for writeback, pipeline stall, misalign/timeout exceptions.
// Ports: clk/rst; opcode_mw/funct3_mw/addr_mw/wdata_mw from the MW register;
//        mem_* data-memory bus; load_data, stall_mw, misalign_exc, fault_exc,
//        bad_addr towards writeback / hazard / CSR logic.
module lsu_mw
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_mw,
  input  logic [2:0]      funct3_mw,
  input  logic [XLEN-1:0] addr_mw,
  input  logic [XLEN-1:0] wdata_mw,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            stall_mw,
  output logic            misalign_exc,
  output logic            fault_exc,
  output logic [XLEN-1:0] bad_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            misalign_q, misalign_d;
  logic            fault_q, fault_d;

  logic            legal_c, misalign_c, is_store_c, start_c, busy_c;
  logic [2:0]      sel_f3_c;
  logic [XLEN-1:0] sel_addr_c, sel_wdata_c;
  logic [3:0]      al_wmask_c;
  logic [XLEN-1:0] al_wdata_c, al_ldata_c;

  // Decode of the instruction currently held in the MW register.
  always_comb begin
    legal_c = 1'b0;
    if (opcode_mw == OPC_LOAD)
      legal_c = funct3_mw inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else if (opcode_mw == OPC_STORE)
      legal_c = funct3_mw inside {F3_B, F3_H, F3_W};
    misalign_c = ((funct3_mw[1:0] == 2'b01) && addr_mw[0]) ||
                 ((funct3_mw[1:0] == 2'b10) && (addr_mw[1:0] != 2'b00));
    is_store_c = (opcode_mw == OPC_STORE);
  end

  assign busy_c  = (state_q == BUSY);
  assign start_c = (state_q == IDLE) && legal_c && !misalign_c && !rst;

  // Request cycle drives from the live inputs; BUSY replays the captured copy.
  assign sel_f3_c    = busy_c ? f3_q    : funct3_mw;
  assign sel_addr_c  = busy_c ? addr_q  : addr_mw;
  assign sel_wdata_c = busy_c ? wdata_q : wdata_mw;

  lsu_align u_align (
    .funct3 (sel_f3_c),
    .off    (sel_addr_c[1:0]),
    .rs2    (sel_wdata_c),
    .rdata  (mem_rdata),
    .wmask  (al_wmask_c),
    .wdata  (al_wdata_c),
    .ldata  (al_ldata_c)
  );

  assign mem_req   = start_c || busy_c;
  assign stall_mw  = mem_req;
  assign mem_we    = mem_req && (busy_c ? we_q : is_store_c);
  assign mem_addr  = mem_req ? {sel_addr_c[XLEN-1:2], 2'b00} : '0;
  assign mem_wmask = mem_we ? al_wmask_c : 4'b0000;
  assign mem_wdata = mem_we ? al_wdata_c : '0;

  assign load_data    = load_data_q;
  assign bad_addr     = bad_addr_q;
  assign misalign_exc = misalign_q;
  assign fault_exc    = fault_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    bad_addr_d  = bad_addr_q;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = BUSY;
          cnt_d   = '0;
          f3_d    = funct3_mw;
          we_d    = is_store_c;
          addr_d  = addr_mw;
          wdata_d = wdata_mw;
        end else if (legal_c && misalign_c) begin
          misalign_d = 1'b1;
          bad_addr_d = addr_mw;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!we_q) load_data_d = al_ldata_c;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d    = 1'b1;
          bad_addr_d = addr_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      bad_addr_q  <= '0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      bad_addr_q  <= bad_addr_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_lsu_mw.sv
// Self-checking bench for lsu_mw: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu_mw;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] NOP   = 7'b0010011;
  localparam logic [6:0] ALU   = 7'b0110011;
  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode_mw = NOP;
  logic [2:0]  funct3_mw = 3'd0;
  logic [31:0] addr_mw = 32'd0, wdata_mw = 32'd0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic [3:0]  mem_wmask;
  logic [31:0] load_data, bad_addr;
  logic        stall_mw, misalign_exc, fault_exc;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ld = 32'd0;

  lsu_mw #(.TIMEOUT(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode_mw(opcode_mw), .funct3_mw(funct3_mw),
    .addr_mw(addr_mw), .wdata_mw(wdata_mw), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(load_data),
    .stall_mw(stall_mw), .misalign_exc(misalign_exc), .fault_exc(fault_exc),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_cycles;
    bit          req_seen;
    bit          unstable;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wmask;
    logic        r_we;
    logic        end_fault, end_misal, end_req;
    logic [31:0] end_ld, end_bad;
    logic        p1_fault, p1_misal, p2_misal;
    logic [31:0] p1_bad;
  } obs_t;

  // Present one instruction, ack in BUSY cycle ack_cyc (cycle 0 = request
  // cycle, -1 = never), optionally also ack during the request cycle.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_cyc,
                        input bit early, output obs_t o);
    int cyc = 0;
    o = '{default: 0};
    opcode_mw = op; funct3_mw = f3; addr_mw = a; wdata_mw = wd;
    mem_rdata = rd; mem_ack = 1'b0;
    while (1) begin
      @(negedge clk);
      if (mem_req === 1'b1) o.req_seen = 1'b1;
      if (stall_mw !== 1'b1 || cyc >= MAXC) break;
      o.stall_cycles++;
      if (mem_req !== 1'b1) o.unstable = 1'b1;
      if (cyc == 0) begin
        o.r_addr = mem_addr; o.r_wdata = mem_wdata;
        o.r_wmask = mem_wmask; o.r_we = mem_we;
      end else if (mem_addr !== o.r_addr || mem_wdata !== o.r_wdata ||
                   mem_wmask !== o.r_wmask || mem_we !== o.r_we) begin
        o.unstable = 1'b1;
      end
      mem_ack = (cyc == ack_cyc) || (early && cyc == 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      cyc++;
    end
    o.end_fault = fault_exc; o.end_misal = misalign_exc; o.end_req = mem_req;
    o.end_ld = load_data; o.end_bad = bad_addr;
    @(posedge clk); #1;
    opcode_mw = NOP; funct3_mw = 3'd0;
    @(negedge clk);
    o.p1_fault = fault_exc; o.p1_misal = misalign_exc; o.p1_bad = bad_addr;
    @(posedge clk); #1;
    @(negedge clk);
    o.p2_misal = misalign_exc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode_mw = NOP;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0 || mem_wmask !== 4'h0) begin n_err++; $display("FAIL reset_we_mask got %b/%h exp 0/0", mem_we, mem_wmask); end
    n_cmp++; if (load_data !== 32'h0) begin n_err++; $display("FAIL reset_load_data got %h exp 0", load_data); end
    n_cmp++; if (misalign_exc !== 1'b0 || fault_exc !== 1'b0) begin n_err++; $display("FAIL reset_exc got %b%b exp 00", misalign_exc, fault_exc); end
    n_cmp++; if (bad_addr !== 32'h0 || stall_mw !== 1'b0) begin n_err++; $display("FAIL reset_bad_stall got %h/%b exp 0/0", bad_addr, stall_mw); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store();
    obs_t o;
    run_op(STORE, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0, o);
    n_cmp++; if (o.stall_cycles !== 3) begin n_err++; $display("FAIL sw_stall got %0d exp 3", o.stall_cycles); end
    n_cmp++; if (o.r_addr !== 32'h100 || o.r_we !== 1'b1) begin n_err++; $display("FAIL sw_addr_we got %h/%b exp 100/1", o.r_addr, o.r_we); end
    n_cmp++; if (o.r_wmask !== 4'b1111 || o.r_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_lanes got %b/%h exp 1111/deadbeef", o.r_wmask, o.r_wdata); end
    n_cmp++; if (o.unstable || o.end_req !== 1'b0) begin n_err++; $display("FAIL sw_hold got unstable=%b done_req=%b exp 0/0", o.unstable, o.end_req); end
    run_op(STORE, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 1'b0, o);
    n_cmp++; if (o.r_wmask !== 4'b1000 || o.r_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_lanes got %b/%h exp 1000/a5a5a5a5", o.r_wmask, o.r_wdata); end
    n_cmp++; if (o.stall_cycles !== 2 || o.r_addr !== 32'h100) begin n_err++; $display("FAIL sb_stall_addr got %0d/%h exp 2/100", o.stall_cycles, o.r_addr); end
    n_cmp++; if (o.end_ld !== exp_ld) begin n_err++; $display("FAIL sb_ld_hold got %h exp %h", o.end_ld, exp_ld); end
  endtask

  task automatic test_load();
    obs_t o;
    run_op(LOAD, 3'b000, 32'h202, 32'h0, 32'h12F03456, 1, 1'b0, o);
    n_cmp++; if (o.end_ld !== 32'hFFFFFFF0) begin n_err++; $display("FAIL lb got %h exp fffffff0", o.end_ld); end
    n_cmp++; if (o.r_wmask !== 4'b0000 || o.r_we !== 1'b0 || o.r_addr !== 32'h200) begin n_err++; $display("FAIL lb_req got %b/%b/%h exp 0000/0/200", o.r_wmask, o.r_we, o.r_addr); end
    run_op(LOAD, 3'b100, 32'h202, 32'h0, 32'h12F03456, 3, 1'b0, o);
    n_cmp++; if (o.end_ld !== 32'h000000F0) begin n_err++; $display("FAIL lbu got %h exp 000000f0", o.end_ld); end
    run_op(LOAD, 3'b101, 32'h202, 32'h0, 32'h12F03456, 1, 1'b0, o);
    n_cmp++; if (o.end_ld !== 32'h000012F0) begin n_err++; $display("FAIL lhu got %h exp 000012f0", o.end_ld); end
    exp_ld = 32'h000012F0;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(LOAD, 3'b010, 32'h301, 32'h0, 32'h0, 1, 1'b0, o);
    n_cmp++; if (o.p1_misal !== 1'b1 || o.p2_misal !== 1'b0 || o.end_misal !== 1'b0) begin n_err++; $display("FAIL misal_pulse got %b%b%b exp 010", o.end_misal, o.p1_misal, o.p2_misal); end
    n_cmp++; if (o.p1_bad !== 32'h301) begin n_err++; $display("FAIL misal_bad got %h exp 301", o.p1_bad); end
    n_cmp++; if (o.req_seen || o.stall_cycles !== 0 || o.p1_fault !== 1'b0) begin n_err++; $display("FAIL misal_noreq got req=%b stall=%0d fault=%b exp 0/0/0", o.req_seen, o.stall_cycles, o.p1_fault); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(LOAD, 3'b010, 32'h400, 32'h0, 32'h55555555, -1, 1'b0, o);
    n_cmp++; if (o.stall_cycles !== 17) begin n_err++; $display("FAIL to_stall got %0d exp 17", o.stall_cycles); end
    n_cmp++; if (o.end_fault !== 1'b1 || o.p1_fault !== 1'b0 || o.end_req !== 1'b0) begin n_err++; $display("FAIL to_pulse got %b%b req=%b exp 10 req=0", o.end_fault, o.p1_fault, o.end_req); end
    n_cmp++; if (o.end_bad !== 32'h400 || o.end_ld !== exp_ld) begin n_err++; $display("FAIL to_bad_ld got %h/%h exp 400/%h", o.end_bad, o.end_ld, exp_ld); end
  endtask

  task automatic test_ack_outside_busy();
    obs_t o;
    run_op(LOAD, 3'b001, 32'h606, 32'h0, 32'h8001_7F00, 3, 1'b1, o);
    n_cmp++; if (o.stall_cycles !== 4) begin n_err++; $display("FAIL early_ack_stall got %0d exp 4", o.stall_cycles); end
    n_cmp++; if (o.end_ld !== 32'hFFFF8001) begin n_err++; $display("FAIL early_ack_lh got %h exp ffff8001", o.end_ld); end
    exp_ld = 32'hFFFF8001;
  endtask

  task automatic test_reset_busy();
    obs_t o;
    opcode_mw = LOAD; funct3_mw = 3'b010; addr_mw = 32'h500; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; opcode_mw = NOP;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstbusy_hold got %b exp 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || stall_mw !== 1'b0 || mem_we !== 1'b0 || mem_wmask !== 4'h0) begin n_err++; $display("FAIL rstbusy_bus got %b%b%b/%h exp 000/0", mem_req, stall_mw, mem_we, mem_wmask); end
    n_cmp++; if (load_data !== 32'h0 || bad_addr !== 32'h0 || fault_exc !== 1'b0 || misalign_exc !== 1'b0) begin n_err++; $display("FAIL rstbusy_regs got %h/%h/%b%b exp 0/0/00", load_data, bad_addr, fault_exc, misalign_exc); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (load_data !== 32'h0) begin n_err++; $display("FAIL rstbusy_late_ack got %h exp 0", load_data); end
    @(posedge clk); #1;
    exp_ld = 32'h0;
    run_op(LOAD, 3'b010, 32'h504, 32'h0, 32'h13572468, 1, 1'b0, o);
    n_cmp++; if (o.stall_cycles !== 2 || o.end_ld !== 32'h13572468) begin n_err++; $display("FAIL rstbusy_idle got %0d/%h exp 2/13572468", o.stall_cycles, o.end_ld); end
    exp_ld = 32'h13572468;
  endtask

  // Back-to-back random instructions against a byte-lane model.
  task automatic test_random();
    obs_t o;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd, emask32, v, ewd;
    logic [3:0]  emask;
    int pick, ack, nbytes, off;
    bit is_ld, is_st, mis, acc;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      op = (pick < 5) ? LOAD : (pick < 9) ? STORE : ALU;
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      ack = $urandom_range(1, 4);
      is_ld = (op == LOAD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      is_st = (op == STORE) && (f3 < 3'd3);
      nbytes = 1 << f3[1:0];
      off = int'(a % 4);
      mis = (is_ld || is_st) && ((a % nbytes) != 0);
      acc = (is_ld || is_st) && !mis;
      emask = 4'b0000; ewd = 32'h0;
      if (acc && is_st) begin
        for (int l = 0; l < 4; l++) begin
          if (l >= off && l < off + nbytes) emask[l] = 1'b1;
          ewd[8*l +: 8] = wd[8*(l % nbytes) +: 8];
        end
      end
      if (acc && is_ld) begin
        v = rd >> (8 * off);
        if (nbytes < 4) begin
          emask32 = (32'd1 << (8 * nbytes)) - 32'd1;
          v = v & emask32;
          if (f3[2] == 1'b0 && v[8*nbytes-1]) v = v | ~emask32;
        end
        exp_ld = v;
      end
      run_op(op, f3, a, wd, rd, ack, 1'b0, o);
      n_cmp++; if (o.stall_cycles !== (acc ? ack + 1 : 0) || o.req_seen !== acc) begin n_err++; $display("FAIL rnd%0d_stall got %0d/%b exp %0d/%b", i, o.stall_cycles, o.req_seen, acc ? ack + 1 : 0, acc); end
      if (acc) begin
        n_cmp++; if (o.r_addr !== {a[31:2], 2'b00} || o.r_we !== is_st || o.r_wmask !== emask) begin n_err++; $display("FAIL rnd%0d_req got %h/%b/%b exp %h/%b/%b", i, o.r_addr, o.r_we, o.r_wmask, {a[31:2], 2'b00}, is_st, emask); end
        n_cmp++; if (o.unstable || o.end_req !== 1'b0) begin n_err++; $display("FAIL rnd%0d_hold got %b/%b exp 0/0", i, o.unstable, o.end_req); end
        if (is_st) begin
          n_cmp++; if (o.r_wdata !== ewd) begin n_err++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o.r_wdata, ewd); end
        end
      end
      n_cmp++; if (o.end_ld !== exp_ld) begin n_err++; $display("FAIL rnd%0d_ld got %h exp %h", i, o.end_ld, exp_ld); end
      n_cmp++; if (o.p1_misal !== mis || o.end_fault !== 1'b0 || o.p1_fault !== 1'b0) begin n_err++; $display("FAIL rnd%0d_exc got m=%b f=%b%b exp m=%b f=00", i, o.p1_misal, o.end_fault, o.p1_fault, mis); end
      if (mis) begin
        n_cmp++; if (o.p1_bad !== a) begin n_err++; $display("FAIL rnd%0d_bad got %h exp %h", i, o.p1_bad, a); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_ack_outside_busy();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mw.md
Name: lsu_mw

Overview:
Load/store unit for the memory-writeback (MW) stage of the 3-stage RV32I pipeline, directly downstream of the MW pipeline register. It consumes the registered opcode/funct3 plus the ALU address and rs2 data, issues one request per access on a req/ack data-memory bus, and formats load data for the writeback mux. It drives stall_mw to freeze the pipeline register while an access is outstanding. It raises misalignment and bus-timeout exceptions to the CSR unit.

Parameters:
TIMEOUT, 16, max BUSY cycles without mem_ack before access fault (≥2)
XLEN, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode_mw  in  7  InstF_MW_opcode from MW register
funct3_mw  in  3  InstF_MW_funct3 from MW register
addr_mw  in  32  effective address (ALU result)
wdata_mw  in  32  rs2 store data
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  1=store
mem_addr  out  32  word-aligned address ({addr_mw[31:2],2'b00})
mem_wmask  out  4  byte enables
mem_wdata  out  32  lane-shifted store data
mem_ack  in  1  completion; mem_rdata valid same cycle for loads
mem_rdata  in  32  read word
load_data  out  32  extended load result for writeback
stall_mw  out  1  hold MW register / PC
misalign_exc  out  1  1-cycle pulse, misaligned access
fault_exc  out  1  1-cycle pulse, bus timeout
bad_addr  out  32  faulting address (mtval)

Behaviour:
- Reset (synchronous): state=IDLE, mem_req=0, mem_we=0, mem_wmask=0, load_data=0, misalign_exc=0, fault_exc=0, bad_addr=0, timeout counter=0. Reset while BUSY drops mem_req next edge; late mem_ack ignored.
- Memory op: opcode 0000011 (load) or 0100011 (store) with legal funct3 (loads 000/001/010/100/101; stores 000/001/010). Other funct3: no access, no exception, no stall.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. No request; misalign_exc pulses, bad_addr=addr_mw; no stall.
- FSM IDLE/BUSY/DONE:
  - IDLE, aligned op: mem_req=1, stall_mw=1 combinationally; next BUSY, counter cleared.
  - BUSY: mem_req, mem_we, mem_addr, mem_wmask, mem_wdata held stable; stall_mw=1. On mem_ack: register formatted load_data; next DONE. Else counter++; at TIMEOUT-1 without ack: drop req, fault_exc pulse, bad_addr=addr_mw, next DONE.
  - DONE: stall_mw=0, mem_req=0; pipeline advances at this edge; next IDLE.
  - Minimum op latency: request cycle + ack cycle + DONE = 3 cycles; back-to-back ops restart from IDLE.
- mem_ack outside BUSY is ignored.
- Store formatting, off=addr[1:0]: SB wmask=0001<<off, wdata={4{rs2[7:0]}}; SH wmask=0011<<off, wdata={2{rs2[15:0]}}; SW wmask=1111, wdata=rs2. mem_wmask=0 for loads.
- Load formatting: select byte/half from rdata by off; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. load_data holds until the next completed load or reset; stores do not change it.
- Exceptions are mutually exclusive and only one pulse per instruction.

Decomposition:
- Shared package riscv_pkg: OPC_LOAD, OPC_STORE, funct3 constants (F3_B/H/W/BU/HU), lsu_state_e enum {IDLE,BUSY,DONE}.
- Sub-module lsu_align (combinational): store lane/mask generation and load extract/extend. FSM, counter and exception logic stay in lsu_mw.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, ack on 2nd BUSY cycle -> mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF, stall_mw high 3 cycles then low in DONE.
- SB addr=0x103 wdata=0x000000A5 -> wmask=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x202, rdata=0x12F03456 -> load_data=0xFFFFFFF0. LBU -> 0x000000F0. LHU addr=0x202 -> 0x000012F0.
- LW addr=0x301 -> misalign_exc one-cycle pulse, bad_addr=0x301, mem_req never asserted, stall_mw=0.
- LW with mem_ack never asserted, TIMEOUT=16 -> fault_exc pulse after 16 BUSY cycles, mem_req drops, next cycle stall_mw=0, load_data unchanged.
- rst asserted in BUSY then mem_ack next cycle -> all outputs at reset values, ack ignored, state IDLE.
